conv_stream_rx_quant: RTL and testbench



---
 rtl/conv_stream_pkg.sv | 28 ++
 rtl/stream_requant.sv | 64 ++++++
 rtl/conv_stream_rx_quant.sv | 160 ++++++++++++++++
 tb/tb_conv_stream_rx_quant.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_stream_pkg.sv
// Shared types and arithmetic helpers for the convolution output stream blocks.
// Rounding is only applied where a block is built with CONV_RX_ROUND_EN.
package conv_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LINE = 2'd1,
    GAP  = 2'd2,
    DROP = 2'd3
  } rx_state_t;

  // Accumulator growth: product of kernel and data widths plus the bits needed to sum matrices.
  function automatic int accWidth(input int kernelW, input int dataW, input int matrixGrowthW);
    return kernelW + dataW + matrixGrowthW;
  endfunction

  function automatic logic [63:0] roundTerm(input int shift);
    if (shift > 0) return 64'd1 << (shift - 1);
    return 64'd0;
  endfunction

  function automatic logic [63:0] satUnsigned(input logic [63:0] val, input int outW);
    logic [63:0] maxVal;
    maxVal = (64'd1 << outW) - 64'd1;
    return (val > maxVal) ? maxVal : val;
  endfunction

endpackage

// File: rtl/stream_requant.sv
// Three-stage requantizer: register, add rounding term and shift, then saturate.
// Round-half-up is enabled by defining CONV_RX_ROUND_EN; otherwise the shift truncates.
module stream_requant
  import conv_stream_pkg::*;
#(
  parameter int IN_WIDTH   = 24,
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT      = 8,
  parameter int SB_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid_i,
  input  logic [IN_WIDTH-1:0]   data_i,
  input  logic [SB_WIDTH-1:0]   sb_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [SB_WIDTH-1:0]   sb_o
);

`ifdef CONV_RX_ROUND_EN
  localparam logic [63:0] RoundTerm64 = roundTerm(SHIFT);
`else
  localparam logic [63:0] RoundTerm64 = 64'd0;
`endif
  localparam logic [IN_WIDTH:0] RoundTerm = RoundTerm64[IN_WIDTH:0];

  logic                  s1Valid_q, s2Valid_q;
  logic [IN_WIDTH-1:0]   s1Data_q;
  logic [IN_WIDTH:0]     s2Data_q, s2Data_d;
  logic [SB_WIDTH-1:0]   s1Sb_q, s2Sb_q;
  logic [DATA_WIDTH-1:0] s3Data_d;

  // The extra top bit keeps the rounding carry so saturation sees the true value.
  always_comb begin
    s2Data_d = ({1'b0, s1Data_q} + RoundTerm) >> SHIFT;
    s3Data_d = DATA_WIDTH'(satUnsigned(64'(s2Data_q), DATA_WIDTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s1Sb_q    <= '0;
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
      s2Sb_q    <= '0;
      valid_o   <= 1'b0;
      data_o    <= '0;
      sb_o      <= '0;
    end else begin
      s1Valid_q <= valid_i;
      s1Data_q  <= data_i;
      s1Sb_q    <= valid_i ? sb_i : '0;
      s2Valid_q <= s1Valid_q;
      s2Data_q  <= s2Data_d;
      s2Sb_q    <= s1Sb_q;
      valid_o   <= s2Valid_q;
      data_o    <= s3Data_d;
      sb_o      <= s2Sb_q;
    end
  end

endmodule

// File: rtl/conv_stream_rx_quant.sv
// Receive side of the convolution stream: framing checker/resync FSM feeding the requantizer.
// Rounding in the datapath is selected by defining CONV_RX_ROUND_EN.
module conv_stream_rx_quant
  import conv_stream_pkg::*;
#(
  parameter int IN_WIDTH    = 24,
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT       = 8,
  parameter int LINE_BEATS  = 224,
  parameter int FRAME_LINES = 224
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             valid_i,
  input  logic [IN_WIDTH-1:0]              data_i,
  input  logic                             sop_i,
  input  logic                             eop_i,
  input  logic                             sof_i,
  input  logic                             eof_i,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             data_valid_o,
  output logic                             sop_o,
  output logic                             eop_o,
  output logic                             sof_o,
  output logic                             eof_o,
  output logic [$clog2(FRAME_LINES+1)-1:0] line_cnt_o,
  output logic                             err_o
);

  localparam int BeatW = $clog2(LINE_BEATS + 1);
  localparam int LineW = $clog2(FRAME_LINES + 1);
  localparam logic [BeatW-1:0] beatsPerLine  = BeatW'(LINE_BEATS);
  localparam logic [LineW-1:0] linesPerFrame = LineW'(FRAME_LINES);

  rx_state_t        state_q, state_d;
  logic [BeatW-1:0] beat_q, beat_d, curBeat, newBeat;
  logic [LineW-1:0] line_q, line_d, curLine;
  logic [LineW-1:0] lineCnt_q, lineCnt_d;
  logic             err_q, errDet, accept, doEval, lastLineHit;
  logic [3:0]       sbOut;

  // A start beat (from IDLE/DROP or GAP) is checked with the same rules as a mid-line
  // beat, just with a zero beat count, so sop&eop on a one-beat line needs no special case.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    line_d      = line_q;
    accept      = 1'b0;
    errDet      = 1'b0;
    doEval      = 1'b0;
    curBeat     = '0;
    curLine     = '0;
    newBeat     = '0;
    lastLineHit = 1'b0;
    if (valid_i) begin
      case (state_q)
        IDLE, DROP: begin
          if (sop_i && sof_i) doEval = 1'b1;
          else state_d = DROP;
        end
        LINE: begin
          if (sop_i || sof_i) errDet = 1'b1;
          else begin
            doEval  = 1'b1;
            curBeat = beat_q;
            curLine = line_q;
          end
        end
        GAP: begin
          if (!sop_i || sof_i) errDet = 1'b1;
          else begin
            doEval  = 1'b1;
            curLine = line_q;
          end
        end
        default: state_d = DROP;
      endcase
      if (doEval) begin
        newBeat     = curBeat + BeatW'(1);
        lastLineHit = (curLine + LineW'(1)) == linesPerFrame;
        if (eop_i) begin
          if (newBeat != beatsPerLine || eof_i != lastLineHit) errDet = 1'b1;
          else if (eof_i) begin
            state_d = IDLE;
            beat_d  = '0;
            line_d  = '0;
            accept  = 1'b1;
          end else begin
            state_d = GAP;
            beat_d  = '0;
            line_d  = curLine + LineW'(1);
            accept  = 1'b1;
          end
        end else if (eof_i || newBeat == beatsPerLine) begin
          errDet = 1'b1;
        end else begin
          state_d = LINE;
          beat_d  = newBeat;
          line_d  = curLine;
          accept  = 1'b1;
        end
      end
      if (errDet) begin
        state_d = DROP;
        beat_d  = '0;
        line_d  = '0;
        accept  = 1'b0;
      end
    end
  end

  // The output line index follows the beats leaving the pipeline, not the FSM.
  always_comb begin
    lineCnt_d = lineCnt_q;
    if (data_valid_o) begin
      if (sof_o) lineCnt_d = '0;
      if (eop_o) lineCnt_d = eof_o ? '0 : ((sof_o ? '0 : lineCnt_q) + LineW'(1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      line_q    <= '0;
      lineCnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      line_q    <= line_d;
      lineCnt_q <= lineCnt_d;
      err_q     <= errDet;
    end
  end

  stream_requant #(
    .IN_WIDTH  (IN_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .SHIFT     (SHIFT),
    .SB_WIDTH  (4)
  ) u_requant (
    .clk    (clk),
    .reset_n(reset_n),
    .valid_i(accept),
    .data_i (data_i),
    .sb_i   ({sop_i, eop_i, sof_i, eof_i}),
    .valid_o(data_valid_o),
    .data_o (data_o),
    .sb_o   (sbOut)
  );

  assign sop_o      = sbOut[3];
  assign eop_o      = sbOut[2];
  assign sof_o      = sbOut[1];
  assign eof_o      = sbOut[0];
  assign line_cnt_o = lineCnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_conv_stream_rx_quant.sv
// Directed bench: a 4x2-frame instance and a 1-beat-line instance, checked with immediate asserts.
// Expected clean-frame data depends on whether CONV_RX_ROUND_EN is defined.
module tb_conv_stream_rx_quant;

`ifdef CONV_RX_ROUND_EN
  localparam logic [7:0] ExpMid = 8'h4B;
`else
  localparam logic [7:0] ExpMid = 8'h4A;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        aValid = 1'b0, aSop = 1'b0, aEop = 1'b0, aSof = 1'b0, aEof = 1'b0;
  logic [23:0] aData = '0;
  logic        bValid = 1'b0, bSop = 1'b0, bEop = 1'b0, bSof = 1'b0, bEof = 1'b0;
  logic [23:0] bData = '0;
  logic [7:0]  aDataO, bDataO;
  logic        aDvO, aSopO, aEopO, aSofO, aEofO, aErrO;
  logic        bDvO, bSopO, bEopO, bSofO, bEofO, bErrO;
  logic [1:0]  aLineO, bLineO;

  conv_stream_rx_quant #(.IN_WIDTH(24), .DATA_WIDTH(8), .SHIFT(8), .LINE_BEATS(4), .FRAME_LINES(2)) dutA (
    .clk(clk), .reset_n(reset_n), .valid_i(aValid), .data_i(aData),
    .sop_i(aSop), .eop_i(aEop), .sof_i(aSof), .eof_i(aEof),
    .data_o(aDataO), .data_valid_o(aDvO), .sop_o(aSopO), .eop_o(aEopO),
    .sof_o(aSofO), .eof_o(aEofO), .line_cnt_o(aLineO), .err_o(aErrO));

  conv_stream_rx_quant #(.IN_WIDTH(24), .DATA_WIDTH(8), .SHIFT(8), .LINE_BEATS(1), .FRAME_LINES(2)) dutB (
    .clk(clk), .reset_n(reset_n), .valid_i(bValid), .data_i(bData),
    .sop_i(bSop), .eop_i(bEop), .sof_i(bSof), .eof_i(bEof),
    .data_o(bDataO), .data_valid_o(bDvO), .sop_o(bSopO), .eop_o(bEopO),
    .sof_o(bSofO), .eof_o(bEofO), .line_cnt_o(bLineO), .err_o(bErrO));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] frm;
    logic [1:0] line;
    int         cyc;
  } beat_t;

  beat_t qA[$];
  beat_t qB[$];
  int cyc = 0;
  int errA = 0, errB = 0;
  int total = 0, bad = 0;
  int inCyc = 0;
  logic [3:0] frameFrm [8] = '{4'b1010, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0101};

  always @(posedge clk) cyc <= cyc + 1;

  // Output beats are captured on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (aDvO) qA.push_back('{aDataO, {aSopO, aEopO, aSofO, aEofO}, aLineO, cyc});
    if (bDvO) qB.push_back('{bDataO, {bSopO, bEopO, bSofO, bEofO}, bLineO, cyc});
    if (aErrO) errA++;
    if (bErrO) errB++;
  end

  function automatic logic [31:0] beatA(input int i, input int field);
    if (i >= qA.size()) return 32'hDEADBEEF;
    case (field)
      0: return 32'(qA[i].data);
      1: return 32'(qA[i].frm);
      2: return 32'(qA[i].line);
      default: return 32'(qA[i].cyc);
    endcase
  endfunction

  function automatic logic [31:0] beatB(input int i, input int field);
    if (i >= qB.size()) return 32'hDEADBEEF;
    case (field)
      0: return 32'(qB[i].data);
      1: return 32'(qB[i].frm);
      default: return 32'(qB[i].line);
    endcase
  endfunction

  function automatic logic [31:0] outVecA();
    return 32'({aDvO, aDataO, aSopO, aEopO, aSofO, aEofO, aErrO, aLineO});
  endfunction

  function automatic logic [31:0] outVecB();
    return 32'({bDvO, bDataO, bSopO, bEopO, bSofO, bEofO, bErrO, bLineO});
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // frm is {sop, eop, sof, eof}; sel picks the instance.
  task automatic applyStimulus(input bit sel, input logic v, input logic [23:0] d, input logic [3:0] frm);
    if (!sel) begin
      aValid = v; aData = d; {aSop, aEop, aSof, aEof} = frm;
    end else begin
      bValid = v; bData = d; {bSop, bEop, bSof, bEof} = frm;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    aValid = 1'b0; bValid = 1'b0;
    {aSop, aEop, aSof, aEof} = 4'b0000;
    {bSop, bEop, bSof, bEof} = 4'b0000;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic sendFrame(input logic [23:0] d);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, d, frameFrm[i]);
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] expData);
    checkOutput({tag, "_count"}, qA.size(), 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), beatA(i, 0), 32'(expData));
      checkOutput($sformatf("%s_frm%0d", tag, i), beatA(i, 1), 32'(frameFrm[i]));
    end
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_a", outVecA(), 0);
    checkOutput("reset_b", outVecB(), 0);
    reset_n = 1'b1;
    idle(2);

    $display("[TB] clean frame");
    qA.delete();
    inCyc = cyc;
    sendFrame(24'h004A80);
    idle(6);
    checkFrame("clean", ExpMid);
    checkOutput("clean_latency", beatA(0, 3) - 32'(inCyc), 3);
    checkOutput("clean_line3", beatA(3, 2), 0);
    checkOutput("clean_line4", beatA(4, 2), 1);
    checkOutput("clean_line7", beatA(7, 2), 1);
    checkOutput("clean_line_end", 32'(aLineO), 0);
    checkOutput("clean_err", errA, 0);

    $display("[TB] saturating frame");
    qA.delete();
    sendFrame(24'h0123FF);
    idle(6);
    checkFrame("sat", 8'hFF);
    checkOutput("sat_err", errA, 0);

    $display("[TB] stray beats before sof");
    qA.delete();
    applyStimulus(1'b0, 1'b1, 24'h004A80, 4'b0000);
    applyStimulus(1'b0, 1'b1, 24'h004A80, 4'b1000);
    applyStimulus(1'b0, 1'b1, 24'h004A80, 4'b0001);
    idle(5);
    checkOutput("stray_count", qA.size(), 0);
    checkOutput("stray_err", errA, 0);

    $display("[TB] early eop");
    qA.delete();
    applyStimulus(1'b0, 1'b1, 24'h000100, 4'b1010);
    applyStimulus(1'b0, 1'b1, 24'h000200, 4'b0000);
    applyStimulus(1'b0, 1'b1, 24'h000300, 4'b0100);
    applyStimulus(1'b0, 1'b1, 24'h000400, 4'b0000);
    applyStimulus(1'b0, 1'b1, 24'h000500, 4'b1000);
    idle(5);
    checkOutput("early_count", qA.size(), 2);
    checkOutput("early_data0", beatA(0, 0), 32'h01);
    checkOutput("early_frm0", beatA(0, 1), 32'b1010);
    checkOutput("early_data1", beatA(1, 0), 32'h02);
    checkOutput("early_err", errA, 1);
    qA.delete();
    sendFrame(24'h004A80);
    idle(6);
    checkFrame("recover", ExpMid);
    checkOutput("recover_err", errA, 1);

    $display("[TB] eof on wrong line");
    qA.delete();
    applyStimulus(1'b0, 1'b1, 24'h004A80, 4'b1010);
    applyStimulus(1'b0, 1'b1, 24'h004A80, 4'b0000);
    applyStimulus(1'b0, 1'b1, 24'h004A80, 4'b0000);
    applyStimulus(1'b0, 1'b1, 24'h004A80, 4'b0101);
    applyStimulus(1'b0, 1'b1, 24'h004A80, 4'b1000);
    applyStimulus(1'b0, 1'b1, 24'h004A80, 4'b0000);
    idle(5);
    checkOutput("eofline_count", qA.size(), 3);
    checkOutput("eofline_err", errA, 2);

    $display("[TB] one-beat lines");
    qB.delete();
    applyStimulus(1'b1, 1'b1, 24'h004A80, 4'b1110);
    applyStimulus(1'b1, 1'b1, 24'h0123FF, 4'b1101);
    idle(6);
    checkOutput("short_count", qB.size(), 2);
    checkOutput("short_data0", beatB(0, 0), 32'(ExpMid));
    checkOutput("short_frm0", beatB(0, 1), 32'b1110);
    checkOutput("short_data1", beatB(1, 0), 32'hFF);
    checkOutput("short_frm1", beatB(1, 1), 32'b1101);
    checkOutput("short_line1", beatB(1, 2), 1);
    checkOutput("short_line_end", 32'(bLineO), 0);
    checkOutput("short_err", errB, 0);

    $display("[TB] reset mid-line");
    qA.delete();
    applyStimulus(1'b0, 1'b1, 24'h004A80, 4'b1010);
    applyStimulus(1'b0, 1'b1, 24'h004A80, 4'b0000);
    applyStimulus(1'b0, 1'b1, 24'h004A80, 4'b0000);
    aValid = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_out", outVecA(), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(5);
    checkOutput("midreset_drain", qA.size(), 0);
    qA.delete();
    sendFrame(24'h004A80);
    idle(6);
    checkFrame("postreset", ExpMid);
    checkOutput("postreset_err", errA, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
